// File: rtl/osd_text_blit_ctrl.sv
// osd_text_blit_ctrl: CLEAR/SCROLL_UP blit engine on the OSD text RAM host port, CPU writes take priority.
// Define OSD_BLIT_VBLANK_EN to restrict engine steps to vertical blank (vde_in=0).
module osd_text_blit_ctrl #(
  parameter logic [19:0] TEXT_BASE = 20'h01000,
  parameter int          RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_fill,
  output logic        busy,
  output logic        done,
  input  logic        cpu_wr_ena,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        vde_in,
  output logic        ram_wr_ena,
  output logic [19:0] ram_addr,
  output logic [7:0]  ram_wr_data,
  input  logic [7:0]  ram_rd_data
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLR_WR  = 3'd1;
  localparam logic [2:0] S_SC_RD   = 3'd2;
  localparam logic [2:0] S_SC_WAIT = 3'd3;
  localparam logic [2:0] S_SC_WR   = 3'd4;
  localparam logic [2:0] S_SC_FILL = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;
  localparam logic [2:0] LAT       = 3'(RD_LAT);
  logic [2:0] state_q, state_d;
  logic [8:0] idx_q, idx_d;
  logic [7:0] fill_q, fill_d;
  logic [7:0] data_q, data_d;
  logic [2:0] cnt_q, cnt_d;
  logic       grant;
  logic       eng_we;
  logic [19:0] eng_addr;
  logic [7:0]  eng_data;
`ifdef OSD_BLIT_VBLANK_EN
  assign grant = !cpu_wr_ena && !vde_in;
`else
  logic unused_vde;
  assign unused_vde = vde_in;
  assign grant = !cpu_wr_ena;
`endif
  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_FIN;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fill_d   = fill_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    eng_we   = 1'b0;
    eng_addr = 20'h0;
    eng_data = 8'h0;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        fill_d  = cmd_fill;
        idx_d   = 9'd0;
        state_d = cmd_op[1] ? S_FIN : (cmd_op[0] ? S_SC_RD : S_CLR_WR);
      end
      S_CLR_WR, S_SC_FILL: begin
        eng_we   = grant;
        eng_addr = TEXT_BASE + {11'b0, idx_q};
        eng_data = fill_q;
        if (grant) begin
          idx_d   = idx_q + 9'd1;
          state_d = (idx_q == 9'd511) ? S_FIN : state_q;
        end
      end
      S_SC_RD: begin
        eng_addr = TEXT_BASE + {11'b0, idx_q + 9'd32};
        if (grant) begin
          cnt_d   = LAT;
          state_d = S_SC_WAIT;
        end
      end
      // the RAM already holds the read address, so waiting is never stalled
      S_SC_WAIT: begin
        eng_addr = TEXT_BASE + {11'b0, idx_q + 9'd32};
        cnt_d    = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          data_d  = ram_rd_data;
          state_d = S_SC_WR;
        end
      end
      S_SC_WR: begin
        eng_we   = grant;
        eng_addr = TEXT_BASE + {11'b0, idx_q};
        eng_data = data_q;
        if (grant) begin
          idx_d   = idx_q + 9'd1;
          state_d = (idx_q == 9'd479) ? S_SC_FILL : S_SC_RD;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign ram_wr_ena  = cpu_wr_ena || eng_we;
  assign ram_addr    = cpu_wr_ena ? cpu_addr : eng_addr;
  assign ram_wr_data = cpu_wr_ena ? cpu_wr_data : eng_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 9'd0;
      fill_q  <= 8'h0;
      data_q  <= 8'h0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_osd_text_blit_ctrl.sv
// tb_osd_text_blit_ctrl: scoreboard bench with a 2-cycle-latency text RAM model behind the host port.
module tb_osd_text_blit_ctrl;
  localparam logic [19:0] BASE = 20'h01000;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_fill = 8'h00;
  logic        busy, done;
  logic        cpu_wr_ena = 1'b0;
  logic [19:0] cpu_addr = 20'h0;
  logic [7:0]  cpu_wr_data = 8'h0;
  logic        vde_in = 1'b0;
  logic        ram_wr_ena;
  logic [19:0] ram_addr;
  logic [7:0]  ram_wr_data;
  logic [7:0]  ram_rd_data;
  logic [7:0]  mem [512];
  logic [7:0]  shadow [512];
  logic [7:0]  rd_p0 = 8'h0, rd_p1 = 8'h0;
  logic        pre_ld = 1'b0;
  logic        cpu_traffic = 1'b0;
  logic [27:0] exp_q [$];
  int n_chk = 0, n_err = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0, n_acc = 0, n_done = 0, n_wr = 0, stall_cnt = 0;

  osd_text_blit_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_fill(cmd_fill), .busy(busy), .done(done),
    .cpu_wr_ena(cpu_wr_ena), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .vde_in(vde_in), .ram_wr_ena(ram_wr_ena), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: address registered, data out RD_LAT=2 cycles after address
  always @(posedge clk) begin
    if (pre_ld) for (int n = 0; n < 512; n++) mem[n] <= 8'(n);
    else if (ram_wr_ena && ram_addr[19:9] == 11'h008) mem[ram_addr[8:0]] <= ram_wr_data;
    rd_p0 <= (ram_addr[19:9] == 11'h008) ? mem[ram_addr[8:0]] : 8'h00;
    rd_p1 <= rd_p0;
  end
  assign ram_rd_data = rd_p1;

  always @(negedge clk) begin
    logic [27:0] e;
    cyc++;
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin acc_cyc = cyc; n_acc++; end
      if (busy && !done && cpu_wr_ena) stall_cnt++;
      if (cpu_wr_ena) begin
        chk("cpu_we", ram_wr_ena, 1);
        chk("cpu_addr", ram_addr, cpu_addr);
        chk("cpu_data", ram_wr_data, cpu_wr_data);
      end else if (ram_wr_ena) begin
        n_wr++;
        if (exp_q.size() == 0) chk("extra_wr", ram_addr, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", ram_addr, e[27:8]);
          chk("wr_data", ram_wr_data, e[7:0]);
        end
      end
      if (done) begin done_cyc = cyc; n_done++; end
    end
  end

  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      k++;
      cpu_wr_ena  = cpu_traffic && (k % 3 == 0);
      cpu_addr    = 20'h08000 + 20'(k);
      cpu_wr_data = 8'(k);
    end
  end

  task automatic push_clear(input logic [7:0] f);
    for (int n = 0; n < 512; n++) begin
      exp_q.push_back({BASE + 20'(n), f});
      shadow[n] = f;
    end
  endtask

  task automatic push_scroll(input logic [7:0] f);
    for (int n = 0; n < 512; n++) begin
      shadow[n] = (n < 480) ? shadow[n+32] : f;
      exp_q.push_back({BASE + 20'(n), shadow[n]});
    end
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [7:0] f, input bit hold);
    int a = n_acc;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_fill = f;
    for (int i = 0; i < 4000 && n_acc == a; i++) @(posedge clk);
    #1;
    chk("accept_timeout", n_acc != a, 1);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int d = n_done;
    for (int i = 0; i < 5000 && n_done == d; i++) @(posedge clk);
    chk("done_timeout", n_done != d, 1);
    @(negedge clk);
    chk("post_done", {busy, done}, 2'b00);
  endtask

  initial begin
    int d1, a, bad;
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, a, bad;
    for (int n = 0; n < 512; n++) begin mem[n] = 8'hEE; shadow[n] = 8'hEE; end
    #12;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_outs", {busy, done, ram_wr_ena, ram_addr, ram_wr_data}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    push_clear(8'h20);
    start_cmd(2'b00, 8'h20, 0);
    wait_done();
    chk("clr_lat", done_cyc - acc_cyc, 513);
    chk("clr_q", exp_q.size(), 0);

    @(posedge clk); #1 pre_ld = 1'b1;
    @(posedge clk); #1 pre_ld = 1'b0;
    for (int n = 0; n < 512; n++) shadow[n] = 8'(n);
    push_scroll(8'h00);
    start_cmd(2'b01, 8'h00, 0);
    wait_done();
    chk("scroll_lat", done_cyc - acc_cyc, 1953);
    chk("scroll_q", exp_q.size(), 0);
    chk("scroll_cell0", mem[0], 8'h20);
    chk("scroll_cell479", mem[479], 8'hFF);
    chk("scroll_cell480", mem[480], 8'h00);

    stall_cnt = 0;
    cpu_traffic = 1'b1;
    push_clear(8'hA5);
    start_cmd(2'b00, 8'hA5, 0);
    wait_done();
    cpu_traffic = 1'b0;
    chk("cpu_late", (done_cyc - acc_cyc) > 513, 1);
    chk("cpu_eng_cycles", done_cyc - acc_cyc - 1 - stall_cnt, 512);
    chk("cpu_q", exp_q.size(), 0);

    push_clear(8'h41);
    push_scroll(8'h55);
    start_cmd(2'b00, 8'h41, 1);
    cmd_op = 2'b01; cmd_fill = 8'h55;
    a = n_acc;
    wait_done();
    d1 = done_cyc;
    for (int i = 0; i < 100 && n_acc == a; i++) @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("hold_acc_count", n_acc - a, 1);
    chk("hold_acc_cyc", acc_cyc - d1, 1);
    wait_done();
    chk("hold_q", exp_q.size(), 0);
    chk("hold_cell480", mem[480], 8'h55);

    for (int n = 0; n < 512; n++) exp_q.push_back({BASE + 20'(n), 8'h33});
    start_cmd(2'b00, 8'h33, 0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ram_wr_ena && ram_addr == BASE + 20'd100) break;
    end
    #2 reset = 1'b1;
    #1;
    chk("abort_outs", {busy, done, ram_wr_ena, ram_addr, ram_wr_data}, 0);
    chk("abort_ready", cmd_ready, 0);
    exp_q.delete();
    for (int n = 0; n < 100; n++) shadow[n] = 8'h33;
    d1 = n_done;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_rel", cmd_ready, 1);
    repeat (5) @(negedge clk);
    chk("abort_no_done", n_done - d1, 0);
    chk("abort_cell99", mem[99], 8'h33);
    chk("abort_cell100", mem[100], 8'h41);

    a = n_wr;
    start_cmd(2'b10, 8'h99, 0);
    wait_done();
    chk("rsv_lat", done_cyc - acc_cyc, 1);
    chk("rsv_writes", n_wr - a, 0);

    vde_in = 1'b1;
    push_clear(8'h7E);
    start_cmd(2'b00, 8'h7E, 0);
`ifdef OSD_BLIT_VBLANK_EN
    repeat (40) @(posedge clk);
    chk("vb_hold", exp_q.size(), 512);
    #1 vde_in = 1'b0;
    wait_done();
`else
    wait_done();
    chk("vde_ignored_lat", done_cyc - acc_cyc, 513);
`endif
    vde_in = 1'b0;
    chk("vde_q", exp_q.size(), 0);

    bad = 0;
    for (int n = 0; n < 512; n++) if (mem[n] !== shadow[n]) bad++;
    chk("mem_final", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
